// File: rtl/path_tracer.sv
// -----------------------------------------------------------------------------
// path_tracer
//
// Walks the predecessor pointers produced by the visited store, starting at a
// destination node and ending at the source node. The resulting path is
// streamed one node index per beat over a valid/ready handshake.
//
// Optional feature macro: PATH_TRACER_FORWARD_ORDER_EN
//   undefined : beats run destination -> source, as the pointers are followed.
//   defined   : the chain is first pushed into a LIFO (FILL state), then
//               popped so beats run source -> destination.
//
// Parameters
//   MAX_NODES   : depth of the predecessor vector and longest possible path
//   INDEX_WIDTH : width of a node index
//
// Ports
//   clock                 : system clock, rising edge
//   reset                 : asynchronous, active-low reset
//   start                 : one-cycle trace request, sampled only when idle
//   number_of_nodes       : count of valid nodes, latched on start
//   source                : node the trace ends at, latched on start
//   destination           : node the trace begins at, latched on start
//   prev_vector_flattened : entry j at [INDEX_WIDTH*j +: INDEX_WIDTH];
//                           must stay stable while busy
//   path_node             : node index of the presented beat
//   path_valid            : path_node / path_last are valid
//   path_ready            : consumer accepts the beat
//   path_last             : presented beat is the final one of this trace
//   busy                  : trace in progress (any state but IDLE)
//   done                  : one-cycle pulse at the end of a trace
//   error                 : trace failed; held until the next accepted start
//   path_length           : beats transferred; valid from done to next start
// -----------------------------------------------------------------------------
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif

module path_tracer #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [INDEX_WIDTH-1:0]         number_of_nodes,
  input  logic [INDEX_WIDTH-1:0]         source,
  input  logic [INDEX_WIDTH-1:0]         destination,
  input  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened,
  output logic [INDEX_WIDTH-1:0]         path_node,
  output logic                           path_valid,
  input  logic                           path_ready,
  output logic                           path_last,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [INDEX_WIDTH-1:0]         path_length
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] cur;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [INDEX_WIDTH-1:0] src_q;

  logic [INDEX_WIDTH-1:0] prev_cur;
  logic                   at_source;
  logic                   unreachable;
  logic [INDEX_WIDTH:0]   next_count;
  logic                   count_limit;
  logic                   terminate;
  logic                   start_bad;

`ifdef PATH_TRACER_FORWARD_ORDER_EN
  localparam int ADDR_WIDTH = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  logic [INDEX_WIDTH-1:0] lifo [MAX_NODES];
  logic [INDEX_WIDTH-1:0] fill_count;
  logic [INDEX_WIDTH-1:0] rd_ptr;
  logic [INDEX_WIDTH-1:0] rd_next;
`endif

  // Predecessor lookup by comparison rather than array indexing, so an index
  // wider than the vector depth selects nothing. An out-of-range index reads
  // as all ones, which is always ">= number_of_nodes" and so "unreachable".
  function automatic logic [INDEX_WIDTH-1:0] prev_of(input logic [INDEX_WIDTH-1:0] idx);
    logic [INDEX_WIDTH-1:0] result;
    result = '1;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (idx == INDEX_WIDTH'(j)) begin
        result = prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH];
      end
    end
    return result;
  endfunction

  assign start_bad = (source >= number_of_nodes) || (destination >= number_of_nodes);

  // Termination decision for the node held in cur. The beat count includes
  // the node being considered, hence the +1 on the count so far.
  // NOTE: every signal driven here gets a value on every pass through the
  // block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    prev_cur    = prev_of(cur);
    at_source   = (cur == src_q);
    unreachable = (prev_cur >= n_q);
`ifdef PATH_TRACER_FORWARD_ORDER_EN
    next_count  = {1'b0, fill_count} + 1'b1;
`else
    next_count  = {1'b0, path_length} + 1'b1;
`endif
    count_limit = (next_count == {1'b0, n_q});
    terminate   = at_source | unreachable | count_limit;
  end

`ifdef PATH_TRACER_FORWARD_ORDER_EN
  assign rd_next   = rd_ptr - 1'b1;
  assign path_last = path_valid & (rd_ptr == '0);

  // NOTE: the LIFO has no reset. Every entry read in WALK was written earlier
  // in the same trace's FILL, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (state == FILL) begin
      lifo[fill_count[ADDR_WIDTH-1:0]] <= cur;
    end
  end
`else
  assign path_last = path_valid & terminate;
`endif

  // NOTE: state registers use non-blocking assignments so every branch below
  // reads the values from before this clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      n_q         <= '0;
      src_q       <= '0;
      path_node   <= '0;
      path_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      path_length <= '0;
`ifdef PATH_TRACER_FORWARD_ORDER_EN
      fill_count  <= '0;
      rd_ptr      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q         <= number_of_nodes;
            src_q       <= source;
            cur         <= destination;
            path_length <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            if (start_bad) begin
              // Indices outside the graph: finish without touching the vector.
              state <= DONE;
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
`ifdef PATH_TRACER_FORWARD_ORDER_EN
              state      <= FILL;
              fill_count <= '0;
`else
              state      <= WALK;
              path_valid <= 1'b1;
              path_node  <= destination;
`endif
            end
          end
        end

`ifdef PATH_TRACER_FORWARD_ORDER_EN
        FILL: begin
          // cur is pushed this cycle by the LIFO write port.
          fill_count <= next_count[INDEX_WIDTH-1:0];
          if (terminate) begin
            if (!at_source) begin
              state <= DONE;
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              // The source is on top of the LIFO and goes out first.
              state      <= WALK;
              path_valid <= 1'b1;
              path_node  <= cur;
              rd_ptr     <= fill_count;
            end
          end else begin
            cur <= prev_cur;
          end
        end

        WALK: begin
          if (path_valid && path_ready) begin
            path_length <= path_length + 1'b1;
            if (rd_ptr == '0) begin
              state      <= DONE;
              path_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              rd_ptr    <= rd_next;
              path_node <= lifo[rd_next[ADDR_WIDTH-1:0]];
            end
          end
        end
`else
        WALK: begin
          if (path_valid && path_ready) begin
            path_length <= next_count[INDEX_WIDTH-1:0];
            if (terminate) begin
              state      <= DONE;
              path_valid <= 1'b0;
              done       <= 1'b1;
              error      <= !at_source;
            end else begin
              cur       <= prev_cur;
              path_node <= prev_cur;
            end
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          path_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_tracer.sv
// -----------------------------------------------------------------------------
// tb_path_tracer
//
// Scoreboard bench for path_tracer. Each trace request runs a reference walk
// over the predecessor array and queues the expected beats and end-of-trace
// result; an independent monitor pops and compares whenever the DUT transfers
// a beat or pulses done.
// -----------------------------------------------------------------------------
module tb_path_tracer;

  localparam int MAX_NODES   = 8;
  localparam int INDEX_WIDTH = 4;

  logic                             clock = 1'b0;
  logic                             reset = 1'b0;
  logic                             start = 1'b0;
  logic [INDEX_WIDTH-1:0]           number_of_nodes = '0;
  logic [INDEX_WIDTH-1:0]           source = '0;
  logic [INDEX_WIDTH-1:0]           destination = '0;
  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened = '0;
  logic [INDEX_WIDTH-1:0]           path_node;
  logic                             path_valid;
  logic                             path_ready = 1'b1;
  logic                             path_last;
  logic                             busy;
  logic                             done;
  logic                             error;
  logic [INDEX_WIDTH-1:0]           path_length;

  path_tracer #(
    .MAX_NODES   (MAX_NODES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .number_of_nodes       (number_of_nodes),
    .source                (source),
    .destination           (destination),
    .prev_vector_flattened (prev_vector_flattened),
    .path_node             (path_node),
    .path_valid            (path_valid),
    .path_ready            (path_ready),
    .path_last             (path_last),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .path_length           (path_length)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [INDEX_WIDTH-1:0] node;
    logic                   last;
  } beat_t;

  typedef struct {
    logic                   err;
    logic [INDEX_WIDTH-1:0] len;
  } result_t;

  int      vectors     = 0;
  int      miscompares = 0;
  int      done_count  = 0;
  int      prev_arr [MAX_NODES];
  beat_t   beat_q   [$];
  result_t result_q [$];
  bit      ready_q  [$];
  bit      rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference walk: follow prev[] from dst until src, a missing predecessor,
  // or n nodes visited. Pushes expected beats and the end result.
  task automatic model_trace(input int n, input int src, input int dst);
    int      path [$];
    int      c;
    bit      err;
    beat_t   b;
    result_t r;
    err = 1'b0;
    if (src >= n || dst >= n) begin
      err = 1'b1;
    end else begin
      c = dst;
      forever begin
        path.push_back(c);
        if (c == src) break;
        if (prev_arr[c] >= n || path.size() == n) begin
          err = 1'b1;
          break;
        end
        c = prev_arr[c];
      end
    end
`ifdef PATH_TRACER_FORWARD_ORDER_EN
    if (err) begin
      path.delete();
    end else begin
      int fwd [$];
      for (int i = path.size() - 1; i >= 0; i--) fwd.push_back(path[i]);
      path = fwd;
    end
`endif
    for (int i = 0; i < path.size(); i++) begin
      b.node = INDEX_WIDTH'(path[i]);
      b.last = (i == path.size() - 1);
      beat_q.push_back(b);
    end
    r.err = err;
    r.len = INDEX_WIDTH'(path.size());
    result_q.push_back(r);
  endtask

  task automatic pack_prev();
    for (int j = 0; j < MAX_NODES; j++) begin
      prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] = INDEX_WIDTH'(prev_arr[j]);
    end
  endtask

  task automatic set_common_prev();
    prev_arr[0] = 5; prev_arr[1] = 0; prev_arr[2] = 1; prev_arr[3] = 1; prev_arr[4] = 5;
    prev_arr[5] = 0; prev_arr[6] = 0; prev_arr[7] = 0;
  endtask

  // Ready driver: an explicit pattern first, then random or constant high.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (ready_q.size() > 0) path_ready = ready_q.pop_front();
      else if (rand_ready)    path_ready = 1'($urandom_range(0, 1));
      else                    path_ready = 1'b1;
    end
  end

  // Monitor: compares transfers and done pulses against the scoreboard.
  logic                   held_valid = 1'b0;
  logic [INDEX_WIDTH-1:0] held_node;
  logic                   held_last;
  logic                   prev_done = 1'b0;

  always @(negedge clock) begin
    beat_t   b;
    result_t r;
    if (reset) begin
      if (held_valid && path_valid) begin
        check("stall_node_stable", path_node, held_node);
        check("stall_last_stable", path_last, held_last);
      end
      held_valid = path_valid && !path_ready;
      held_node  = path_node;
      held_last  = path_last;
      if (path_valid && path_ready) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", path_node, 32'hFFFF_FFFF);
        end else begin
          b = beat_q.pop_front();
          check("beat_node", path_node, b.node);
          check("beat_last", path_last, b.last);
        end
      end
      if (done) begin
        check("done_one_cycle", prev_done, 1'b0);
        check("valid_low_in_done", path_valid, 1'b0);
        if (result_q.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          r = result_q.pop_front();
          check("result_error", error, r.err);
          check("result_length", path_length, r.len);
        end
        done_count++;
      end
      prev_done = done;
    end else begin
      held_valid = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic run_trace(input int n, input int src, input int dst, input bit inject);
    int start_done;
    int cycles;
    int exp_beats;
    pack_prev();
    number_of_nodes = INDEX_WIDTH'(n);
    source          = INDEX_WIDTH'(src);
    destination     = INDEX_WIDTH'(dst);
    model_trace(n, src, dst);
    exp_beats  = beat_q.size();
    start_done = done_count;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
`ifndef PATH_TRACER_FORWARD_ORDER_EN
    check("valid_after_start", path_valid, exp_beats > 0);
`endif
    if (inject) begin
      @(posedge clock);
      #1;
      start       = 1'b1;
      destination = '0;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    cycles = 0;
    while (done_count == start_done && cycles < 400) begin
      @(posedge clock);
      cycles++;
    end
    check("done_seen", done_count != start_done, 1'b1);
    check("beats_drained", beat_q.size(), 0);
    beat_q.delete();
    result_q.delete();
    @(posedge clock);
    #1;
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    int n;
    // Reset held across two edges: every output cleared.
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_path_node", path_node, 0);
    check("rst_path_valid", path_valid, 0);
    check("rst_path_last", path_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_path_length", path_length, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    set_common_prev();
    // Normal trace 2 -> 1 -> 0.
    run_trace(5, 0, 2, 1'b0);
    // Backpressure on 3 -> 1 -> 0.
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_trace(5, 0, 3, 1'b0);
    // Single-beat trace and invalid destination.
    run_trace(5, 2, 2, 1'b0);
    run_trace(5, 0, 7, 1'b0);
    // Unreachable destination.
    run_trace(5, 0, 4, 1'b0);
    // Loop guard.
    prev_arr[1] = 2;
    prev_arr[2] = 1;
    run_trace(5, 0, 2, 1'b0);
    set_common_prev();
    // Start pulsed mid-trace is ignored.
    ready_q = '{1'b0, 1'b0, 1'b0};
    run_trace(5, 0, 2, 1'b1);

    // Reset asserted mid-trace abandons it.
    pack_prev();
    number_of_nodes = 5;
    source          = 0;
    destination     = 2;
    ready_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
`ifndef PATH_TRACER_FORWARD_ORDER_EN
    check("valid_before_reset", path_valid, 1'b1);
`endif
    reset = 1'b0;
    #1;
    check("valid_drops_on_reset", path_valid, 1'b0);
    check("busy_drops_on_reset", busy, 1'b0);
    beat_q.delete();
    result_q.delete();
    @(posedge clock);
    #1;
    ready_q.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    run_trace(5, 0, 2, 1'b0);

    // Randomized graphs, endpoints and backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(1, MAX_NODES);
      for (int j = 0; j < MAX_NODES; j++) prev_arr[j] = $urandom_range(0, 9);
      run_trace(n, $urandom_range(0, n), $urandom_range(0, n), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
